// File: rtl/nibble_stream_decrypt_ctrl_pkg.sv
// Shared encodings for the nibble-serial decrypt controller.
package nibble_stream_decrypt_ctrl_pkg;
    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;
endpackage

// File: rtl/nibble_stream_decrypt_ctrl_dec.sv
// 4-bit block decryptor: swap adjacent bit pairs, then XOR with the key.
module blockDecryptor_4bit (
    input  logic [3:0] c,
    input  logic [3:0] k,
    output logic [3:0] p
);
    assign p = {c[2], c[3], c[0], c[1]} ^ k;
endmodule

// File: rtl/nibble_stream_decrypt_ctrl.sv
// Walks a ciphertext word through the 4-bit decryptor one nibble per clock,
// with optional CBC chaining that persists across words.
module nibble_stream_decrypt_ctrl
    import nibble_stream_decrypt_ctrl_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cfg_we,
    input  logic [3:0]                cfg_key,
    input  logic [3:0]                cfg_iv,
    input  logic                      cfg_cbc,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NIBBLE_W*NIBBLES-1:0] in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NIBBLE_W*NIBBLES-1:0] out_data,
    output logic                      busy
);
    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    state_t               state_q, state_d;
    logic [3:0]           key_q, chain_q;
    logic                 cbc_q;
    logic [IDX_W-1:0]     idx_q;
    logic [W-1:0]         sh_q, res_q, out_data_q;
    // [0]: result complete, [1]: result presented on the output register
    logic [1:0]           vld_pipe;
    logic [3:0]           dec_p, p;
    logic                 cfg_ok, accept, last, handshake;

    blockDecryptor_4bit u_dec (
        .c (sh_q[NIBBLE_W-1:0]),
        .k (key_q),
        .p (dec_p)
    );

    assign in_ready  = (state_q == ST_IDLE) && !cfg_we;
    assign cfg_ok    = (state_q == ST_IDLE) && cfg_we;
    assign accept    = in_valid && in_ready;
    assign last      = (idx_q == IDX_W'(NIBBLES - 1));
    assign handshake = vld_pipe[1] && out_ready;
    assign p         = dec_p ^ (cbc_q ? chain_q : 4'h0);

    assign out_valid = vld_pipe[1];
    assign out_data  = out_data_q;
    assign busy      = (state_q != ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept)    state_d = ST_RUN;
            ST_RUN:  if (last)      state_d = ST_DONE;
            ST_DONE: if (handshake) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    // The IV only matters as the chain's starting value, so it lives in chain_q.
    always_ff @(posedge clk) begin
        if (reset) begin
            key_q      <= '0;
            chain_q    <= '0;
            cbc_q      <= 1'b0;
            idx_q      <= '0;
            sh_q       <= '0;
            res_q      <= '0;
            out_data_q <= '0;
            vld_pipe   <= '0;
        end else begin
            if (cfg_ok) begin
                key_q   <= cfg_key;
                chain_q <= cfg_iv;
                cbc_q   <= cfg_cbc;
            end
            if (accept) begin
                sh_q  <= in_data;
                idx_q <= '0;
            end
            if (state_q == ST_RUN) begin
                res_q[idx_q*NIBBLE_W +: NIBBLE_W] <= p;
                sh_q <= sh_q >> NIBBLE_W;
                if (cbc_q) chain_q <= sh_q[NIBBLE_W-1:0];
                if (last) vld_pipe[0] <= 1'b1;
                else      idx_q <= idx_q + IDX_W'(1);
            end
            if (state_q == ST_DONE) begin
                if (handshake) begin
                    vld_pipe <= '0;
                end else if (vld_pipe[0]) begin
                    vld_pipe   <= 2'b10;
                    out_data_q <= res_q;
                end
            end
        end
    end
endmodule

// File: tb/tb_nibble_stream_decrypt_ctrl.sv
// Self-checking bench: directed plan cases plus random words vs a word-level model.
module tb_nibble_stream_decrypt_ctrl;
    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         reset, cfg_we, cfg_cbc, in_valid, in_ready, out_valid, out_ready, busy;
    logic [3:0]   cfg_key, cfg_iv;
    logic [W-1:0] in_data, out_data;

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0] m_key, m_chain;
    logic       m_cbc;

    always #5 clk = ~clk;

    nibble_stream_decrypt_ctrl #(.NIBBLES(N)) dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_key(cfg_key), .cfg_iv(cfg_iv),
        .cfg_cbc(cfg_cbc), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] swap_pairs(input logic [3:0] c);
        logic [3:0] lo, hi;
        lo = c & 4'h5;
        hi = c & 4'hA;
        return (lo << 1) | (hi >> 1);
    endfunction

    task automatic model_word(input logic [W-1:0] c, output logic [W-1:0] pw);
        logic [3:0] cn, pn;
        pw = '0;
        for (int i = 0; i < N; i++) begin
            cn = c[i*4 +: 4];
            pn = swap_pairs(cn) ^ m_key;
            if (m_cbc) begin
                pn      = pn ^ m_chain;
                m_chain = cn;
            end
            pw[i*4 +: 4] = pn;
        end
    endtask

    task automatic cfg_write(input logic [3:0] k, input logic [3:0] iv, input logic cbc);
        @(negedge clk);
        cfg_we = 1'b1; cfg_key = k; cfg_iv = iv; cfg_cbc = cbc;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        m_key = k; m_chain = iv; m_cbc = cbc;
    endtask

    // Sends one word; use_exp selects a fixed expected value over the model's.
    task automatic send(input logic [W-1:0] data, input int hold, input bit poke,
                        input bit use_exp, input logic [W-1:0] exp_fixed);
        logic [W-1:0] exp_m, exp;
        int lat;
        model_word(data, exp_m);
        exp = use_exp ? exp_fixed : exp_m;
        @(negedge clk);
        in_valid = 1'b1; in_data = data;
        #1 chk("in_ready_idle", 64'(in_ready), 64'(1));
        @(posedge clk); #1;
        in_data = W'($urandom);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            in_data = W'($urandom);
        end
        in_valid = 1'b0;
        chk("latency", 64'(lat), 64'(N + 1));
        chk("out_data", 64'(out_data), 64'(exp));
        chk("busy_done", 64'(busy), 64'(1));
        chk("in_ready_done", 64'(in_ready), 64'(0));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (poke && h == 2) begin
                cfg_we = 1'b1; cfg_key = ~m_key; cfg_iv = ~m_chain; cfg_cbc = ~m_cbc;
            end else begin
                cfg_we = 1'b0;
            end
            @(posedge clk); #1;
            chk("stall_valid", 64'(out_valid), 64'(1));
            chk("stall_data", 64'(out_data), 64'(exp));
        end
        @(negedge clk);
        cfg_we = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("valid_drop", 64'(out_valid), 64'(0));
        chk("busy_idle", 64'(busy), 64'(0));
        chk("in_ready_after", 64'(in_ready), 64'(1));
    endtask

    initial begin
        logic [W-1:0] w;
        reset = 1'b1; cfg_we = 1'b0; cfg_key = '0; cfg_iv = '0; cfg_cbc = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        m_key = '0; m_chain = '0; m_cbc = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_data", 64'(out_data), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        reset = 1'b0;

        // Reset config is ECB, key 0: pure pair swap.
        send(16'h1234, 0, 0, 1, 16'h2138);
        cfg_write(4'h3, 4'h0, 1'b0);
        send(16'hA5C3, 0, 0, 1, 16'h69F0);
        cfg_write(4'h3, 4'h0, 1'b1);
        send(16'hA5C3, 0, 0, 1, 16'h35C0);
        send(16'h0000, 0, 0, 1, 16'h3339);
        cfg_write(4'h0, 4'h0, 1'b0);
        send(16'h1234, 0, 0, 1, 16'h2138);

        // Backpressure with an ignored config pulse; next word keeps old chain.
        cfg_write(4'h3, 4'h0, 1'b1);
        send(16'hA000, 10, 1, 0, '0);
        send(16'h5C3A, 0, 0, 0, '0);

        // Config and a word in the same IDLE cycle: config wins.
        @(negedge clk);
        cfg_we = 1'b1; cfg_key = 4'h5; cfg_iv = 4'h0; cfg_cbc = 1'b0;
        in_valid = 1'b1; in_data = 16'h0F0F;
        #1 chk("cfg_blocks_ready", 64'(in_ready), 64'(0));
        @(posedge clk); #1;
        cfg_we = 1'b0; in_valid = 1'b0;
        m_key = 4'h5; m_chain = 4'h0; m_cbc = 1'b0;
        chk("cfg_no_accept", 64'(busy), 64'(0));
        send(16'h0F0F, 0, 0, 0, '0);

        // Reset on the second RUN cycle.
        cfg_write(4'h9, 4'h7, 1'b1);
        @(negedge clk);
        in_valid = 1'b1; in_data = 16'hBEEF;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midrun_valid", 64'(out_valid), 64'(0));
        chk("midrun_busy", 64'(busy), 64'(0));
        chk("midrun_ready", 64'(in_ready), 64'(1));
        reset = 1'b0;
        m_key = '0; m_chain = '0; m_cbc = 1'b0;
        cfg_write(4'h3, 4'h0, 1'b0);
        send(16'h0000, 0, 0, 1, 16'h3333);
        cfg_write(4'h3, 4'h0, 1'b1);
        send(16'h0000, 0, 0, 1, 16'h3333);

        // Random words with occasional reconfiguration.
        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 3) == 0)
                cfg_write(4'($urandom), 4'($urandom), 1'($urandom));
            w = W'($urandom);
            send(w, $urandom_range(0, 3), 1'($urandom), 0, '0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
